seq_display_ctrl: RTL and testbench

Playback sequencer for the Simon sequence on the seven-segment display. On start it walks the sequence memory and presents each stored digit to the sevenSeg decoder for a timed ON window, followed by a blanked OFF gap. It also keeps the player's two-digit BCD score for the score displays. Sits between the game FSM, the sequence RAM and the sevenSeg decoder instances.

---
 rtl/simon_pkg.sv | 23 ++
 rtl/bcd_score_counter.sv | 45 ++++
 rtl/seq_display_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seq_display_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// -----------------------------------------------------------------------------
// simon_pkg
// Shared types and constants for the Simon display path.
//   disp_state_t : playback sequencer states (IDLE..DONE)
//   DIGIT_BLANK  : code the sevenSeg decoder renders as an unlit digit
//   bcd_t        : one BCD digit
// -----------------------------------------------------------------------------
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHOW  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } disp_state_t;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_score_counter.sv
// -----------------------------------------------------------------------------
// bcd_score_counter
// Two-digit BCD score, 00..99, saturating at 99. Clear wins over increment.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (score -> 00)
//   inc          : add one to the score
//   clr          : force the score to 00
//   tens, ones   : registered BCD digits
// -----------------------------------------------------------------------------
module bcd_score_counter
  import simon_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output bcd_t tens,
  output bcd_t ones
);

  // Returns {tens, ones} after one increment, holding at 99.
  function automatic logic [7:0] bcd_sat_inc(input bcd_t t, input bcd_t o);
    logic [7:0] r;
    if (t == 4'd9 && o == 4'd9)
      r = {t, o};
    else if (o == 4'd9)
      r = {t + 4'd1, 4'd0};
    else
      r = {t, o + 4'd1};
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      {tens, ones} <= bcd_sat_inc(tens, ones);
    end
  end

endmodule

// File: rtl/seq_display_ctrl.sv
// -----------------------------------------------------------------------------
// seq_display_ctrl
// Plays the stored Simon sequence on the seven-segment digit: each digit is
// fetched from the sequence RAM, shown for ON_CYCLES, then blanked for
// OFF_CYCLES. Also hosts the two-digit BCD player score.
//
// Optional build macro SEQ_ABORT_EN: adds an 'abort' input that returns a
// running playback to IDLE (blank, not busy, no done pulse).
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : one-cycle pulse, accepted only in IDLE
//   seq_len               : digits to play, clipped to MAX_LEN, sampled on start
//   abort                 : (SEQ_ABORT_EN only) cancel playback
//   mem_addr / mem_data   : sequence RAM address / data (data one clock later)
//   busy                  : high from accepted start until DONE completes
//   done                  : one-cycle pulse at the end of playback
//   digit_code            : to sevenSeg decoder, 4'hF = blank
//   score_inc, score_clr  : score controls (clear wins)
//   score_tens, score_ones: BCD score digits
// -----------------------------------------------------------------------------
module seq_display_ctrl
  import simon_pkg::*;
#(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int MAX_LEN    = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   seq_len,
`ifdef SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic [3:0]        digit_code,
  input  logic              score_inc,
  input  logic              score_clr,
  output bcd_t              score_tens,
  output bcd_t              score_ones
);

  localparam int TIMER_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX);

  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [ADDR_W:0]    LEN_MAX  = (ADDR_W + 1)'(MAX_LEN);

  disp_state_t        state;
  logic [TIMER_W-1:0] timer;
  logic [ADDR_W:0]    idx;
  logic [ADDR_W:0]    len;
  logic [ADDR_W:0]    len_clip;
  logic [ADDR_W:0]    idx_next;
  logic               abort_req;

`ifdef SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign len_clip = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
  assign idx_next = idx + 1'b1;

  // Playback sequencer. Every output is updated on the transition that
  // enters the state it belongs to, so all outputs come straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_addr   <= '0;
      digit_code <= DIGIT_BLANK;
      idx        <= '0;
      len        <= '0;
      timer      <= '0;
    end else begin
      done <= 1'b0;
      if (abort_req && state != IDLE) begin
        state      <= IDLE;
        busy       <= 1'b0;
        digit_code <= DIGIT_BLANK;
        timer      <= '0;
      end else begin
        case (state)
          IDLE: begin
            digit_code <= DIGIT_BLANK;
            if (start) begin
              len   <= len_clip;
              idx   <= '0;
              timer <= '0;
              if (len_clip == '0) begin
                // Nothing to play: address left untouched, straight to DONE.
                state <= DONE;
              end else begin
                state    <= FETCH;
                busy     <= 1'b1;
                mem_addr <= '0;
              end
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            // RAM data for mem_addr is valid during this cycle.
            digit_code <= mem_data;
            timer      <= '0;
            state      <= SHOW;
          end
          SHOW: begin
            if (timer == ON_LAST) begin
              timer      <= '0;
              digit_code <= DIGIT_BLANK;
              state      <= GAP;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          GAP: begin
            if (timer == OFF_LAST) begin
              timer <= '0;
              if (idx_next < len) begin
                // idx_next < len <= MAX_LEN <= 2**ADDR_W, so the slice is exact.
                idx      <= idx_next;
                mem_addr <= idx_next[ADDR_W-1:0];
                state    <= FETCH;
              end else begin
                state <= DONE;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  bcd_score_counter u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (score_inc),
    .clr     (score_clr),
    .tens    (score_tens),
    .ones    (score_ones)
  );

endmodule

// File: tb/tb_seq_display_ctrl.sv
module tb_seq_display_ctrl;

  localparam int ON     = 3;
  localparam int OFF    = 2;
  localparam int P      = ON + OFF + 2;
  localparam int ADDR_W = 4;
  localparam int MAXL   = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   seq_len = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_data = 4'h0;
  logic              busy, done;
  logic [3:0]        digit_code;
  logic              score_inc = 1'b0, score_clr = 1'b0;
  logic [3:0]        score_tens, score_ones;
`ifdef SEQ_ABORT_EN
  logic              abort = 1'b0;
`endif

  logic [3:0] ram [MAXL];
  int checks = 0;
  int passed = 0;
  int score = 0;
  int prev_addr = 0;

  always #5 clk = ~clk;

  // Sequence RAM with one clock of read latency.
  always @(posedge clk) mem_data <= ram[mem_addr];

  seq_display_ctrl #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .MAX_LEN    (MAXL),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .seq_len    (seq_len),
`ifdef SEQ_ABORT_EN
    .abort      (abort),
`endif
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (busy),
    .done       (done),
    .digit_code (digit_code),
    .score_inc  (score_inc),
    .score_clr  (score_clr),
    .score_tens (score_tens),
    .score_ones (score_ones)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: cycle c counts from the first cycle after the accepting edge.
  // Each digit occupies P cycles: 2 blank (fetch/load), ON lit, OFF blank.
  // Then one blank busy cycle, then one cycle with done high and busy low.
  task automatic expect_at(input int c, input int eff, output logic [3:0] d,
                           output logic b, output logic dn, output int a);
    if (eff == 0) begin
      d = 4'hF; b = 1'b0; dn = (c == 1); a = prev_addr;
    end else if (c < eff * P) begin
      int i, ph;
      i = c / P; ph = c % P;
      d = (ph >= 2 && ph < 2 + ON) ? ram[i] : 4'hF;
      b = 1'b1; dn = 1'b0; a = i;
    end else begin
      d = 4'hF; b = (c == eff * P); dn = (c == eff * P + 1); a = eff - 1;
    end
  endtask

  task automatic check_cycle(input int c, input int eff);
    logic [3:0] d; logic b, dn; int a;
    expect_at(c, eff, d, b, dn, a);
    check("digit_code", digit_code, d);
    check("busy", busy, b);
    check("done", done, dn);
    check("mem_addr", mem_addr, 8'(a));
  endtask

  // Play a sequence of 'len' digits; a second start (seq_len=2) is injected at
  // cycle restart_c when restart_c >= 0.
  task automatic run_play(input int len, input int restart_c);
    int eff, total;
    eff   = (len > MAXL) ? MAXL : len;
    total = (eff == 0) ? 3 : eff * P + 3;
    @(negedge clk);
    start = 1'b1; seq_len = (ADDR_W + 1)'(len);
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      start = (c == restart_c);
      if (start) seq_len = 5'd2;
      check_cycle(c, eff);
    end
    start = 1'b0;
    if (eff > 0) prev_addr = eff - 1;
  endtask

  task automatic check_score(input string tag);
    check({tag, "_tens"}, score_tens, 8'(score / 10));
    check({tag, "_ones"}, score_ones, 8'(score % 10));
  endtask

  task automatic score_step(input logic inc, input logic clr);
    @(negedge clk);
    score_inc = inc; score_clr = clr;
    @(negedge clk);
    score_inc = 1'b0; score_clr = 1'b0;
    if (clr) score = 0;
    else if (inc && score < 99) score++;
    check_score("score");
  endtask

  initial begin
    ram[0] = 4'd3; ram[1] = 4'd7; ram[2] = 4'd1; ram[3] = 4'd9;
    for (int i = 4; i < MAXL; i++) ram[i] = 4'($urandom_range(0, 15));

    // Reset state
    #12;
    check("rst_digit", digit_code, 8'hF);
    check("rst_busy", busy, 8'd0);
    check("rst_done", done, 8'd0);
    check("rst_addr", mem_addr, 8'd0);
    check_score("rst");
    @(negedge clk); reset_n = 1'b1;

    run_play(4, -1);
    run_play(0, -1);
    run_play(20, -1);
    run_play(4, P + 2);

    // Score: saturation, carry, clear priority
    score_step(1'b0, 1'b1);
    for (int i = 0; i < 100; i++) score_step(1'b1, 1'b0);
    check("sat99", {score_tens, score_ones}, 8'h99);
    score_step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) score_step(1'b1, 1'b0);
    check("carry10", {score_tens, score_ones}, 8'h10);
    score_step(1'b0, 1'b1);
    for (int i = 0; i < 45; i++) score_step(1'b1, 1'b0);
    check("at45", {score_tens, score_ones}, 8'h45);
    score_step(1'b1, 1'b1);
    check("clr_wins", {score_tens, score_ones}, 8'h00);
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 15);
      score_step(r < 12, r == 15);
    end

    // Reset asserted during SHOW of the first digit
    @(negedge clk); start = 1'b1; seq_len = 5'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    score = 0; prev_addr = 0;
    check("mid_rst_digit", digit_code, 8'hF);
    check("mid_rst_busy", busy, 8'd0);
    check("mid_rst_done", done, 8'd0);
    check_score("mid_rst");
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_done", done, 8'd0);
      check("post_rst_busy", busy, 8'd0);
    end

`ifdef SEQ_ABORT_EN
    // Abort in the GAP of the third digit
    @(negedge clk); start = 1'b1; seq_len = 5'd4;
    for (int c = 0; c <= 2 * P + 2 + ON; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_cycle(c, 4);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_digit", digit_code, 8'hF);
    check("abort_busy", busy, 8'd0);
    check("abort_done", done, 8'd0);
    check("abort_addr", mem_addr, 8'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_done", done, 8'd0);
    end
    prev_addr = 2;
    run_play(4, -1);
`endif

    // Random playbacks with fresh RAM contents
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < MAXL; i++) ram[i] = 4'($urandom_range(0, 15));
      run_play($urandom_range(0, 7), -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
